// File: rtl/mips_pkg.sv
// mips_pkg: shared types and constants for the MIPS HI/LO multiply/divide unit.
//   muldiv_op_t    : opcode encoding presented on mips_muldiv.op
//   muldiv_state_t : sequencer states of mips_muldiv
//   MULDIV_ITERS   : number of single-bit iterations per MULT/DIV
package mips_pkg;

    typedef enum logic [2:0] {
        OP_MULTU = 3'b000,
        OP_MULT  = 3'b001,
        OP_DIVU  = 3'b010,
        OP_DIV   = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } muldiv_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PREP = 2'd1,
        S_RUN  = 2'd2,
        S_FIX  = 2'd3
    } muldiv_state_t;

    localparam int MULDIV_ITERS = 32;

endpackage

// File: rtl/mips_muldiv_step.sv
// mips_muldiv_step: one combinational iteration of the HI/LO datapath.
//   div_i : 1 = restoring-divide step, 0 = shift-add multiply step
//   acc_i : 64-bit accumulator in; multiply {partial, multiplier},
//           divide {remainder, dividend/quotient}
//   b_i   : multiplicand or divisor magnitude
//   acc_o : accumulator after one iteration
module mips_muldiv_step (
    input  logic        div_i,
    input  logic [63:0] acc_i,
    input  logic [31:0] b_i,
    output logic [63:0] acc_o
);

    logic [32:0] sum;
    logic [32:0] rem_sh;
    logic        ge;
    logic [31:0] diff;

    always_comb begin
        // Multiply: add multiplicand into the upper half when the LSB of the
        // multiplier is set, then shift the whole accumulator right by one.
        sum    = {1'b0, acc_i[63:32]} + (acc_i[0] ? {1'b0, b_i} : 33'd0);
        // Divide: shift the next dividend bit into the remainder. The
        // remainder stays below the divisor, so a successful subtract always
        // fits in 32 bits.
        rem_sh = acc_i[63:31];
        ge     = rem_sh >= {1'b0, b_i};
        diff   = rem_sh[31:0] - b_i;
        if (div_i)
            acc_o = ge ? {diff, acc_i[30:0], 1'b1} : {rem_sh[31:0], acc_i[30:0], 1'b0};
        else
            acc_o = {sum, acc_i[31:1]};
    end

endmodule

// File: rtl/mips_muldiv.sv
// mips_muldiv: iterative MIPS multiply/divide unit with HI/LO registers.
//   clk, rst_n       : clock, synchronous active-low reset
//   start, op        : request strobe and opcode (muldiv_op_t)
//   src_a, src_b     : operands (src_a also carries MTHI/MTLO data)
//   busy             : PREP/RUN/FIX in progress
//   done             : one-cycle pulse when HI/LO take a MULT/DIV result
//   div_by_zero      : pulses with done for a divide by zero
//   hi, lo           : HI/LO registers
// Build option: MIPS_MULDIV_SIGNED_EN enables signed MULT/DIV; without it
// MULT/DIV behave as MULTU/DIVU and no sign logic exists.
module mips_muldiv
    import mips_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    output logic              busy,
    output logic              done,
    output logic              div_by_zero,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    muldiv_state_t state_q;
    logic [5:0]    cnt_q;
    logic [63:0]   acc_q, acc_step;
    logic [31:0]   a_q, b_q, a_mag, b_mag;
    logic          div_q, bz_q;
    logic [31:0]   hi_q, lo_q, hi_d, lo_d;
    logic          done_q, dbz_q;
`ifdef MIPS_MULDIV_SIGNED_EN
    logic          sgn_q, neg_q, rneg_q;
    logic          a_neg, b_neg;
`endif

    mips_muldiv_step u_step (
        .div_i (div_q),
        .acc_i (acc_q),
        .b_i   (b_q),
        .acc_o (acc_step)
    );

`ifdef MIPS_MULDIV_SIGNED_EN
    assign a_neg = sgn_q & a_q[31];
    assign b_neg = sgn_q & b_q[31];
    assign a_mag = a_neg ? -a_q : a_q;
    assign b_mag = b_neg ? -b_q : b_q;
`else
    assign a_mag = a_q;
    assign b_mag = b_q;
`endif

    // Result as written to HI/LO on leaving FIX.
    always_comb begin
        hi_d = acc_q[63:32];
        lo_d = acc_q[31:0];
`ifdef MIPS_MULDIV_SIGNED_EN
        if (div_q) begin
            if (neg_q)  lo_d = -acc_q[31:0];
            if (rneg_q) hi_d = -acc_q[63:32];
        end else if (neg_q) begin
            {hi_d, lo_d} = -acc_q;
        end
`endif
        // Divide by zero reports the raw dividend, never sign-corrected.
        if (bz_q) begin
            hi_d = a_q;
            lo_d = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            div_q   <= 1'b0;
            bz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
`ifdef MIPS_MULDIV_SIGNED_EN
            sgn_q   <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            case (state_q)
                S_IDLE: if (start) begin
                    case (op)
                        OP_MULTU, OP_MULT, OP_DIVU, OP_DIV: begin
                            a_q     <= src_a;
                            b_q     <= src_b;
                            div_q   <= op[1];
`ifdef MIPS_MULDIV_SIGNED_EN
                            sgn_q   <= op[0];
`endif
                            state_q <= S_PREP;
                        end
                        OP_MTHI: hi_q <= src_a;
                        OP_MTLO: lo_q <= src_a;
                        default: ;
                    endcase
                end
                S_PREP: begin
                    acc_q   <= {32'd0, a_mag};
                    b_q     <= b_mag;
                    bz_q    <= div_q && (b_q == '0);
`ifdef MIPS_MULDIV_SIGNED_EN
                    neg_q   <= a_neg ^ b_neg;
                    rneg_q  <= a_neg;
`endif
                    cnt_q   <= '0;
                    state_q <= S_RUN;
                end
                S_RUN: begin
                    acc_q <= acc_step;
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'(MULDIV_ITERS - 1)) state_q <= S_FIX;
                end
                S_FIX: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    done_q  <= 1'b1;
                    dbz_q   <= bz_q;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_mips_muldiv.sv
// tb_mips_muldiv: randomized self-checking bench for mips_muldiv against an
// arithmetic reference model. Honors MIPS_MULDIV_SIGNED_EN like the design.
module tb_mips_muldiv;

    logic        clk = 1'b0;
    logic        rst_n, start, busy, done, div_by_zero;
    logic [2:0]  op;
    logic [31:0] src_a, src_b, hi, lo;

    int checks   = 0;
    int failures = 0;

    mips_muldiv #(.DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference result {div_by_zero, hi, lo} from plain arithmetic.
    function automatic logic [64:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        bit          sgn;
        sgn = 1'b0;
`ifdef MIPS_MULDIV_SIGNED_EN
        sgn = o[0];
`endif
        if (!o[1]) begin
            if (sgn) p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
            else     p = {32'd0, a} * {32'd0, b};
            return {1'b0, p};
        end
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'd0, 32'h8000_0000};
            return {1'b0, 32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
        end
        return {1'b0, a % b, a / b};
    endfunction

    // Issue one MULT/DIV and watch 40 cycles. With disturb set, operands
    // wiggle and stray starts (including MTLO/MULT) are fired while busy.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input bit disturb);
        logic [64:0] exp;
        int busy_n, done_n, done_at;
        logic [31:0] hi_s, lo_s;
        logic        dbz_s;
        exp = model(o, a, b);
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(negedge clk);
        start = 1'b0;
        busy_n = 0; done_n = 0; done_at = 0; hi_s = '0; lo_s = '0; dbz_s = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_at == 0) begin
                    done_at = c; hi_s = hi; lo_s = lo; dbz_s = div_by_zero;
                end
            end
            if (disturb && c <= 33) begin
                src_a = $urandom; src_b = $urandom;
                op    = 3'($urandom_range(0, 5));
                start = (c % 5 == 2);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        chk({tag, ".busy_cycles"}, 64'(busy_n), 64'd34);
        chk({tag, ".done_cycle"},  64'(done_at), 64'd35);
        chk({tag, ".done_pulses"}, 64'(done_n), 64'd1);
        chk({tag, ".hi"},  {32'd0, hi_s}, {32'd0, exp[63:32]});
        chk({tag, ".lo"},  {32'd0, lo_s}, {32'd0, exp[31:0]});
        chk({tag, ".dbz"}, {63'd0, dbz_s}, {63'd0, exp[64]});
        chk({tag, ".hold"}, {hi, lo}, exp[63:0]);
    endtask

    initial begin
        // Reset with a coincident MTHI request that must be ignored.
        rst_n = 1'b0; start = 1'b1; op = 3'd4; src_a = 32'hDEAD_BEEF; src_b = '0;
        @(negedge clk); @(negedge clk);
        chk("rst.hi", {32'd0, hi}, 64'd0);
        chk("rst.lo", {32'd0, lo}, 64'd0);
        chk("rst.ctl", {61'd0, busy, done, div_by_zero}, 64'd0);
        rst_n = 1'b1; start = 1'b0;
        @(negedge clk);

        // MTHI / MTLO while idle.
        start = 1'b1; op = 3'd4; src_a = 32'h1234_5678;
        @(negedge clk);
        start = 1'b0;
        chk("mthi.hi", {32'd0, hi}, 64'h1234_5678);
        chk("mthi.lo", {32'd0, lo}, 64'd0);
        chk("mthi.ctl", {62'd0, busy, done}, 64'd0);
        start = 1'b1; op = 3'd5; src_a = 32'h0BAD_F00D;
        @(negedge clk);
        start = 1'b0;
        chk("mtlo.lo", {32'd0, lo}, 64'h0BAD_F00D);
        chk("mtlo.hi", {32'd0, hi}, 64'h1234_5678);

        // Directed corner cases.
        run_op("multu_max", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("mult_m3x7", 3'd1, 32'hFFFF_FFFD, 32'd7, 1'b1);
        run_op("div_m7d2",  3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("divu_d0",   3'd2, 32'd100, 32'd0, 1'b1);
        run_op("div_d0",    3'd3, 32'h8000_0001, 32'd0, 1'b0);
        run_op("div_ovf",   3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("mult_neg",  3'd1, 32'h8000_0000, 32'h8000_0000, 1'b0);

        // Reset in the middle of a DIVU discards it.
        @(negedge clk);
        start = 1'b1; op = 3'd2; src_a = 32'd12345; src_b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst.busy", {63'd0, busy}, 64'd0);
        chk("midrst.hilo", {hi, lo}, 64'd0);
        begin
            int dn = 0;
            for (int c = 0; c < 40; c++) begin
                if (done) dn++;
                @(negedge clk);
            end
            chk("midrst.nodone", 64'(dn), 64'd0);
        end
        run_op("after_rst", 3'd0, 32'd40000, 32'd70000, 1'b0);

        // Randomized operations, occasionally dividing by zero.
        for (int i = 0; i < 16; i++) begin
            logic [2:0]  ro;
            logic [31:0] ra, rb;
            ro = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
            run_op($sformatf("rand%0d", i), ro, ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_muldiv.md
MIPS_MULDIV -- requirements
Module: mips_muldiv

Interface
REQ-001 The block SHALL have one parameter: DATA_W, default 32, operand/HI/LO width; only 32 is supported.
REQ-002 Port: clk  input  1  rising-edge clock; one clock only.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: start  input  1  request strobe, sampled on the rising edge of clk.
REQ-005 Port: op  input  3  opcode: 000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO; other codes are no-op.
REQ-006 Port: src_a  input  32  multiplicand, dividend, or MTHI/MTLO data.
REQ-007 Port: src_b  input  32  multiplier or divisor.
REQ-008 Port: busy  output  1  high while an iterative operation is in flight.
REQ-009 Port: done  output  1  one-cycle pulse when HI/LO hold a new MULT/DIV result.
REQ-010 Port: div_by_zero  output  1  pulses with done when a DIV/DIVU had src_b==0.
REQ-011 Port: hi  output  32  HI register, a direct register output.
REQ-012 Port: lo  output  32  LO register, a direct register output.

Function
REQ-013 FSM states SHALL be IDLE, PREP, RUN and FIX; the block leaves IDLE only on an accepted MULT/DIV.
REQ-014 A start SHALL be accepted only in IDLE; a start while busy SHALL be ignored with no state, HI or LO change.
REQ-015 In IDLE, MTHI/MTLO with start SHALL write src_a to hi/lo at the same edge, with no busy and no done.
REQ-016 For an accepted MULT/DIV at edge N, the FSM SHALL move to PREP at N+1, RUN for 32 cycles (N+2..N+33) and FIX at N+34, then return to IDLE.
REQ-017 busy SHALL be high for exactly the PREP, RUN and FIX cycles, i.e. 34 cycles.
REQ-018 In the cycle after FIX, done SHALL pulse for exactly one cycle, with hi/lo updated and valid from that cycle.
REQ-019 PREP SHALL latch the operands; signed ops convert operands to magnitude and record the result and remainder signs.
REQ-020 RUN SHALL do multiplication as 1-bit-per-cycle shift-add into a 64-bit accumulator, with a 6-bit iteration counter from 0 to 31.
REQ-021 RUN SHALL do division as 1-bit-per-cycle restoring division, with the quotient to LO and the remainder to HI.
REQ-022 FIX SHALL apply two's-complement sign correction: the product takes the XOR of the operand signs; the quotient takes the XOR of the operand signs; the remainder takes the dividend's sign.
REQ-023 MULT/MULTU SHALL write HI to product[63:32] and LO to product[31:0].
REQ-024 Divide by zero SHALL give LO=0xFFFFFFFF and HI=src_a, with no sign correction, and div_by_zero pulsing with done.
REQ-025 DIV of 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0, with no flag.
REQ-026 Operands SHALL be captured at acceptance; src_a/src_b changes during busy SHALL have no effect.
REQ-027 hi/lo SHALL hold their values between operations; they change only at the done edge or on an MTHI/MTLO write.

Reset
REQ-028 rst_n low at an edge SHALL force IDLE with busy=0, done=0, div_by_zero=0, hi=0, lo=0 and counter=0, including mid-operation (the result is discarded).
REQ-029 A start coincident with rst_n low SHALL be ignored.

Configuration
REQ-030 The macro MIPS_MULDIV_SIGNED_EN defined SHALL enable signed MULT/DIV per REQ-019, REQ-022 and REQ-025.
REQ-031 With MIPS_MULDIV_SIGNED_EN undefined, MULT SHALL execute as MULTU and DIV as DIVU, and no sign-correction logic is synthesised; latency is unchanged.

Structure
REQ-032 A shared package mips_pkg SHALL hold the op enum (muldiv_op_t), the FSM state enum, and the constant MULDIV_ITERS=32.
REQ-033 The datapath step SHALL be one sub-module, mips_muldiv_step: a combinational single-iteration shift-add / restoring-subtract cell; the FSM, counter and HI/LO stay in mips_muldiv.

Verification
REQ-034 MULTU 0xFFFFFFFF x 0xFFFFFFFF SHALL give hi=0xFFFFFFFE and lo=0x00000001, with done exactly 35 cycles after the start edge and busy high for 34 cycles.
REQ-035 MULT -3 x 7 (SIGNED_EN defined) SHALL give hi=0xFFFFFFFF and lo=0xFFFFFFEB; with the macro undefined, hi=0x00000006 and lo=0xFFFFFFEB.
REQ-036 DIV -7 / 2 SHALL give lo=0xFFFFFFFD and hi=0xFFFFFFFF; DIVU 100/0 SHALL give lo=0xFFFFFFFF, hi=100 and div_by_zero=1 for one cycle.
REQ-037 MTHI 0x12345678 while idle SHALL set hi next edge, with busy=0 and done=0; a MTLO or second MULT issued during busy SHALL be ignored, leaving lo as the MULT result.
REQ-038 rst_n low at cycle 10 of a DIVU SHALL give next cycle busy=0, hi=lo=0 and no done; a new MULTU accepted afterwards SHALL complete normally.
